// File: rtl/stepper_phase_decoder.sv
// Receive-side decoder for the 4-wire half-step stepper phase interface.
// Synchronizes and glitch-filters the raw phase lines, then tracks the
// half-step index to produce a signed position, direction, step strobe,
// step period and sticky error flag.
module stepper_phase_decoder #(
  parameter int FILTER_CYCLES = 4,
  parameter int POS_W         = 16,
  parameter int PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          stepper_signals,
  input  logic                clear_position,
  input  logic                clear_error,
  output logic [POS_W-1:0]    position,
  output logic                step_pulse,
  output logic                direction,
  output logic                phase_valid,
  output logic                locked,
  output logic                step_error,
  output logic [PERIOD_W-1:0] step_period,
  output logic                idle
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] FMAX = CNT_W'(FILTER_CYCLES);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  // Returns {legal, index}; 0000 and illegal patterns both report legal=0.
  function automatic logic [3:0] decode_phase(input logic [3:0] p);
    case (p)
      4'b1000: decode_phase = 4'b1_000;
      4'b1100: decode_phase = 4'b1_001;
      4'b0100: decode_phase = 4'b1_010;
      4'b0110: decode_phase = 4'b1_011;
      4'b0010: decode_phase = 4'b1_100;
      4'b0011: decode_phase = 4'b1_101;
      4'b0001: decode_phase = 4'b1_110;
      4'b1001: decode_phase = 4'b1_111;
      default: decode_phase = 4'b0_000;
    endcase
  endfunction

  logic [3:0]          sync1_q, sync2_q;
  logic [3:0]          cand_q, cand_d;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d;
  logic [3:0]          filt_q, filt_d;
  logic [3:0]          prev_q;
  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic                step_q, step_d;
  logic                dir_q, dir_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d, err_set;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [3:0]          dec;
  logic [2:0]          diff;

  // Two-flop synchronizer on the asynchronous phase lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= stepper_signals;
      sync2_q <= sync2_q == sync1_q ? sync2_q : sync1_q;
    end
  end

  // Glitch filter: count consecutive equal samples; accept on the Nth one.
  always_comb begin
    cand_d = cand_q;
    fcnt_d = fcnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      fcnt_d = CNT_W'(1);
    end else if (fcnt_q != FMAX) begin
      fcnt_d = fcnt_q + CNT_W'(1);
    end
    filt_d = (fcnt_d == FMAX) ? sync2_q : filt_q;
  end

  // Filter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= '0;
      fcnt_q <= '0;
      filt_q <= '0;
    end else begin
      cand_q <= cand_d;
      fcnt_q <= fcnt_d;
      filt_q <= filt_d;
    end
  end

  assign dec  = decode_phase(filt_q);
  assign diff = dec[2:0] - idx_q;

  // Decoder next state: acts only when the filtered pattern changes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    valid_d = valid_q;
    err_set = 1'b0;
    if (filt_q != prev_q) begin
      valid_d = dec[3];
      if (!dec[3]) begin
        state_d = UNLOCKED;
        err_set = (filt_q != 4'b0000);
      end else if (state_q == UNLOCKED) begin
        state_d = LOCKED;
        idx_d   = dec[2:0];
      end else begin
        idx_d = dec[2:0];
        if (diff == 3'd1) begin
          step_d = 1'b1;
          dir_d  = 1'b1;
        end else if (diff == 3'd7) begin
          step_d = 1'b1;
          dir_d  = 1'b0;
        end else begin
          err_set = 1'b1;
        end
      end
    end
    err_d = err_set | (err_q & ~clear_error);
    if (clear_position)
      pos_d = '0;
    else if (step_d)
      pos_d = dir_d ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    else
      pos_d = pos_q;
    if (step_d) begin
      pcnt_d   = PERIOD_W'(1);
      period_d = pcnt_q;
    end else begin
      pcnt_d   = (&pcnt_q) ? pcnt_q : pcnt_q + PERIOD_W'(1);
      period_d = period_q;
    end
  end

  // Decoder, position and period registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q   <= '0;
      state_q  <= UNLOCKED;
      idx_q    <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      pos_q    <= '0;
      pcnt_q   <= '0;
      period_q <= '0;
    end else begin
      prev_q   <= filt_q;
      state_q  <= state_d;
      idx_q    <= idx_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      pos_q    <= pos_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
    end
  end

  assign position    = pos_q;
  assign step_pulse  = step_q;
  assign direction   = dir_q;
  assign phase_valid = valid_q;
  assign locked      = (state_q == LOCKED);
  assign step_error  = err_q;
  assign step_period = period_q;
  assign idle        = &pcnt_q;

endmodule
